poci_serializer: RTL and testbench
==================================

# poci_serializer

Parallel-to-serial readout stage for the POCI line. It runs in the SPI clock domain and sits directly downstream of the PICO address/write block. It consumes that block's byte-boundary flag (`msg_flag`) and address pointer, plus the POCI mux output (`rd_data`). For each byte slot it returns either a sync header or the addressed register byte, MSB first. It also keeps a data-byte count and a running checksum of everything sent.

## Interface
- `SYNC_BYTE`, default 8'hA5, header byte shifted out while an address byte is being received.
- `sclk`  input  1  SPI clock; all state updates on posedge.
- `rst`  input  1  asynchronous, active-high reset. Top level drives it as the inverse of (external rstn AND clock-comparator sclk_stop_rstn).
- `msg_flag`  input  1  byte-boundary flag from PICO; high during the first sclk cycle of each byte.
- `addr_ptr`  input  8  PICO address pointer (mux control); 0 means "next byte is an address".
- `rd_data`  input  8  POCI mux output for `addr_ptr`.
- `poci`  output  1  serial readout bit (shift register bit 7).
- `tx_active`  output  1  high in HDR or DATA state.
- `data_count`  output  8  data bytes loaded since reset; saturates at 255.
- `checksum`  output  8  sum modulo 256 of all data bytes loaded since reset.

## Operation
- State machine, 2-bit encoding: IDLE=0, HDR=1, DATA=2. Code 3 is illegal and goes to IDLE on the next edge.
- Internal 8-bit shift register `sr`; `poci` = `sr[7]`.
- On each posedge sclk with `msg_flag`=1 (load edge):
  - `addr_ptr`==0: `sr` <= `SYNC_BYTE`, state <= HDR. Counters are unchanged.
  - `addr_ptr`!=0: `sr` <= `rd_data`, state <= DATA, `data_count` <= sat(`data_count`+1), `checksum` <= `checksum` + `rd_data` (8-bit wrap).
- Posedge with `msg_flag`=0:
  - State HDR or DATA: `sr` <= {`sr[6:0]`, 1'b0}.
  - State IDLE: `sr` holds.
- Transaction flow follows from PICO's flow:
  - First byte (address phase): `addr_ptr`=0, so SYNC_BYTE is returned.
  - Byte n≥2: returns reg[addr+n-2], because PICO advances the pointer once per byte.
- Pointer wrap: 0xFF→0x00 in PICO makes the next slot an address slot. This block returns SYNC_BYTE there and goes back to HDR.
- The block never leaves HDR/DATA except on `rst`. End of transaction is signalled only by `rst` (the sclk-stop reset).

## Timing
- Reset (async assert, any time including mid-byte):
  - `sr`=0, `poci`=0, state=IDLE, `tx_active`=0, `data_count`=0, `checksum`=0.
- Reset release: PICO's bit counter is 0, so `msg_flag` is high. The first posedge after release is a load edge.
- Load latency:
  - Bit 7 of the loaded byte is on `poci` after the load edge.
  - Bit k is valid for the sclk period following edge (load+7-k).
  - Full byte takes 8 edges; no gap between consecutive bytes.
- `rd_data` and `addr_ptr` are sampled only at the load edge. PICO updates `addr_ptr` on the rising edge of `msg_flag`, one full sclk period before that load edge, so the mux has a full period to settle.
- `data_count`, `checksum` and `tx_active` update on the load edge, registered with no combinational path from inputs.
- `msg_flag` held high for several consecutive edges (degenerate upstream case): every such edge is a load edge.
- Saturation: `data_count` stays at 255 on further loads; `checksum` continues to wrap.
- Reset asserted on the same edge as a load: reset wins and nothing is loaded.

## Test plan
- Reset then 8 sclk, `msg_flag`=1 on edge 1 only, `addr_ptr`=0 → `poci` = 1,0,1,0,0,1,0,1 after edges 1-8. `tx_active` rises after edge 1; `data_count`=0.
- Three-byte transaction: `addr_ptr`=0x10 at edge 9 with `rd_data`=0x3C, then 0x11 at edge 17 with `rd_data`=0xF0 → byte 2 shifts out 0x3C, byte 3 shifts out 0xF0. `data_count`=2, `checksum`=0x2C.
- Wrap: `addr_ptr` goes 0xFF then 0x00 → the 0xFF slot returns `rd_data`; the 0x00 slot returns 0xA5 and the state returns to HDR.
- Mid-byte reset: assert `rst` after edge 4 of a data byte → `poci`=0, `tx_active`=0 and both counters 0 immediately. After release, the next edge loads SYNC_BYTE.
- Saturation: 260 data loads with `rd_data`=0x01 → `data_count`=255, `checksum`=0x04.
- `msg_flag` held high 3 edges with `addr_ptr`=0x05 and `rd_data` = 0x11, 0x22, 0x33 → `poci` equals bit 7 of each loaded byte in turn (0, 0, 0). `data_count`=3, `checksum`=0x66.

Source files
------------

// File: rtl/poci_serializer.sv
// poci_serializer
// Parallel-to-serial readout stage for the POCI line, clocked by the SPI clock.
// At each byte boundary it loads either the sync header (address slot) or the
// addressed register byte, then shifts it out MSB first. It also tracks a
// saturating data-byte count and a mod-256 checksum of every data byte loaded.
//
// Ports
//   sclk        in   SPI clock; all state updates on posedge
//   rst         in   asynchronous active-high reset (sclk-stop / external reset)
//   msg_flag    in   byte-boundary flag from PICO; every posedge with it high loads
//   addr_ptr    in   [7:0] PICO address pointer; 0 marks an address slot
//   rd_data     in   [7:0] POCI mux output for addr_ptr
//   poci        out  serial readout bit (shift register MSB)
//   tx_active   out  high in HDR or DATA
//   data_count  out  [7:0] data bytes loaded since reset, saturating at 255
//   checksum    out  [7:0] sum mod 256 of data bytes loaded since reset
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, nothing loaded yet; shift register holds
// HDR   | shifting out SYNC_BYTE (address byte being received)
// DATA  | shifting out a register byte
// 3     | illegal; returns to IDLE on the next non-load edge

module poci_serializer #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       msg_flag,
    input  logic [7:0] addr_ptr,
    input  logic [7:0] rd_data,
    output logic       poci,
    output logic       tx_active,
    output logic [7:0] data_count,
    output logic [7:0] checksum
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0] state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [7:0] data_count_q, data_count_d;
    logic [7:0] checksum_q, checksum_d;

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        data_count_d = data_count_q;
        checksum_d   = checksum_q;

        if (msg_flag) begin
            // A load edge overrides whatever state we are in, including illegal.
            if (addr_ptr == 8'h00) begin
                sr_d    = SYNC_BYTE;
                state_d = ST_HDR;
            end else begin
                sr_d         = rd_data;
                state_d      = ST_DATA;
                data_count_d = (data_count_q == 8'hFF) ? data_count_q
                                                       : data_count_q + 8'd1;
                checksum_d   = checksum_q + rd_data;
            end
        end else begin
            case (state_q)
                ST_HDR, ST_DATA: sr_d = {sr_q[6:0], 1'b0};
                ST_IDLE:         sr_d = sr_q;
                default:         state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sr_q         <= 8'h00;
            data_count_q <= 8'h00;
            checksum_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            data_count_q <= data_count_d;
            checksum_q   <= checksum_d;
        end
    end

    // Outputs decode only registered state, so nothing combinational reaches them from inputs.
    assign poci       = sr_q[7];
    assign tx_active  = (state_q == ST_HDR) || (state_q == ST_DATA);
    assign data_count = data_count_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_poci_serializer.sv
module tb_poci_serializer;

    logic       sclk;
    logic       rst;
    logic       msg_flag;
    logic [7:0] addr_ptr;
    logic [7:0] rd_data;
    logic       poci;
    logic       tx_active;
    logic [7:0] data_count;
    logic [7:0] checksum;

    int n_total;
    int n_bad;

    // Reference model: the byte currently on the line and how many bits have gone by.
    int  m_byte;
    int  m_pos;
    bit  m_active;
    int  m_count;
    int  m_sum;

    poci_serializer #(.SYNC_BYTE(8'hA5)) dut (
        .sclk       (sclk),
        .rst        (rst),
        .msg_flag   (msg_flag),
        .addr_ptr   (addr_ptr),
        .rd_data    (rd_data),
        .poci       (poci),
        .tx_active  (tx_active),
        .data_count (data_count),
        .checksum   (checksum)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: total=%0d bad=%0d required=finish", n_total, n_bad);
        $fatal(1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_poci();
        if (!m_active || m_pos > 7) return 0;
        return (m_byte >> (7 - m_pos)) & 1;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".poci"},  32'(poci),       exp_poci());
        chk({tag, ".act"},   32'(tx_active),  int'(m_active));
        chk({tag, ".cnt"},   32'(data_count), m_count);
        chk({tag, ".sum"},   32'(checksum),   m_sum);
    endtask

    // Called just after a negedge: drive, take one posedge, update model, check at next negedge.
    task automatic step(input string tag, input bit flag, input int ptr, input int data);
        msg_flag = flag;
        addr_ptr = 8'(ptr);
        rd_data  = 8'(data);
        @(posedge sclk);
        if (flag) begin
            m_active = 1'b1;
            m_pos    = 0;
            if (ptr == 0) begin
                m_byte = 'hA5;
            end else begin
                m_byte  = data & 'hFF;
                m_count = (m_count + 1 > 255) ? 255 : m_count + 1;
                m_sum   = (m_sum + (data & 'hFF)) % 256;
            end
        end else if (m_active) begin
            m_pos++;
        end
        @(negedge sclk);
        check_all(tag);
    endtask

    task automatic byte_slot(input string tag, input int ptr, input int data);
        step(tag, 1'b1, ptr, data);
        for (int i = 0; i < 7; i++) step(tag, 1'b0, $urandom_range(0, 255), $urandom_range(0, 255));
    endtask

    // Assert reset between edges, check async clear, release before the next posedge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        m_active = 1'b0;
        m_pos    = 8;
        m_byte   = 0;
        m_count  = 0;
        m_sum    = 0;
        check_all(tag);
        @(negedge sclk);
        rst = 1'b0;
    endtask

    initial begin
        n_total  = 0;
        n_bad    = 0;
        rst      = 1'b1;
        msg_flag = 1'b1;
        addr_ptr = 8'h00;
        rd_data  = 8'h00;
        m_active = 1'b0;
        m_pos    = 8;
        m_byte   = 0;
        m_count  = 0;
        m_sum    = 0;
        repeat (2) @(negedge sclk);
        check_all("rst0");
        rst = 1'b0;

        // Address slot right after release returns the sync header.
        byte_slot("hdr", 0, 8'h77);

        // Three-byte transaction continues with two data bytes.
        byte_slot("b2", 8'h10, 8'h3C);
        byte_slot("b3", 8'h11, 8'hF0);
        chk("txn.cnt", 32'(data_count), 2);
        chk("txn.sum", 32'(checksum), 'h2C);

        // Pointer wrap: 0xFF slot is data, 0x00 slot is header again.
        byte_slot("wrapff", 8'hFF, $urandom_range(0, 255));
        byte_slot("wrap00", 0, $urandom_range(0, 255));

        // Mid-byte reset after edge 4 of a data byte.
        step("mid", 1'b1, 5, 8'hC3);
        for (int i = 0; i < 3; i++) step("mid", 1'b0, 5, 8'hC3);
        do_reset("midrst");
        byte_slot("after", 0, 8'h5A);

        // Random traffic: address/data mix, variable slot length including held flag.
        for (int n = 0; n < 40; n++) begin
            int ptr;
            int nsh;
            ptr = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255);
            nsh = $urandom_range(0, 7);
            step("rnd", 1'b1, ptr, $urandom_range(0, 255));
            for (int i = 0; i < nsh; i++) step("rnd", 1'b0, $urandom_range(0, 255), $urandom_range(0, 255));
        end

        // Saturation: 260 back-to-back loads of 0x01.
        @(negedge sclk);
        do_reset("satrst");
        for (int i = 0; i < 260; i++) step("sat", 1'b1, 1, 1);
        chk("sat.cnt", 32'(data_count), 255);
        chk("sat.sum", 32'(checksum), 'h04);

        // msg_flag held high for three edges.
        do_reset("hldrst");
        step("hold1", 1'b1, 5, 8'h11);
        step("hold2", 1'b1, 5, 8'h22);
        step("hold3", 1'b1, 5, 8'h33);
        chk("hold.cnt", 32'(data_count), 3);
        chk("hold.sum", 32'(checksum), 'h66);
        for (int i = 0; i < 9; i++) step("tail", 1'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
